// File: rtl/dmem_access_ctrl_pkg.sv
// dmem_access_ctrl_pkg: shared mem_op encodings, field positions and FSM states
//   mem_op layout: [4:3] op, [2] sign, [1:0] length
package dmem_access_ctrl_pkg;
    localparam int OP_MSB   = 4;
    localparam int OP_LSB   = 3;
    localparam int SIGN_BIT = 2;
    localparam int LEN_MSB  = 1;
    localparam int LEN_LSB  = 0;

    typedef enum logic [1:0] {
        MEM_NO_OP = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } mem_op_e;

    typedef enum logic {
        MEM_SIGNED   = 1'b0,
        MEM_UNSIGNED = 1'b1
    } mem_sign_e;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_len_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ1,
        S_WAIT1,
        S_REQ2,
        S_WAIT2,
        S_RESP
    } state_e;
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane mask, store shift and load extract/extend
//   i_off    byte offset within the word
//   i_len    access length (BYTE/HALF/WORD)
//   i_sign   MEM_SIGNED sign-extends loads
//   i_wdata  right-aligned store data
//   i_rword  {hi, lo} words read from the bus
//   o_mask   7-bit lane mask spanning two words
//   o_wdata  store data shifted into its lanes across two words
//   o_rdata  extracted and extended load result
module dmem_lane_align
    import dmem_access_ctrl_pkg::*;
(
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_len,
    input  logic        i_sign,
    input  logic [31:0] i_wdata,
    input  logic [63:0] i_rword,
    output logic [6:0]  o_mask,
    output logic [63:0] o_wdata,
    output logic [31:0] o_rdata
);
    logic [3:0]  w_base;
    logic [31:0] w_sh;
    logic        w_ext;

    assign w_base  = (i_len == MEM_BYTE) ? 4'b0001 : (i_len == MEM_HALF) ? 4'b0011 : 4'b1111;
    assign o_mask  = {3'b000, w_base} << i_off;
    assign o_wdata = {32'b0, i_wdata} << {i_off, 3'b000};
    assign w_sh    = 32'(i_rword >> {i_off, 3'b000});
    assign w_ext   = (i_sign == MEM_SIGNED);
    assign o_rdata = (i_len == MEM_BYTE) ? {{24{w_ext & w_sh[7]}}, w_sh[7:0]} :
                     (i_len == MEM_HALF) ? {{16{w_ext & w_sh[15]}}, w_sh[15:0]} : w_sh;
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: data-memory access sequencer between MEM stage and a req/gnt/rvalid bus
//   Build option MEM_SPLIT_EN: word-crossing accesses run as two bus beats;
//   without it they are rejected with o_misalign and never reach the bus.
//   Pipeline side: i_req_valid, i_mem_op, i_addr, i_wdata -> o_stall, o_done, o_rdata, o_misalign
//   Bus side:      o_dm_req, o_dm_we, o_dm_addr, o_dm_be, o_dm_wdata <- i_dm_gnt, i_dm_rvalid, i_dm_rdata
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req_valid,
    input  logic [4:0]    i_mem_op,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic          o_stall,
    output logic          o_done,
    output logic [DW-1:0] o_rdata,
    output logic          o_misalign,
    output logic          o_dm_req,
    output logic          o_dm_we,
    output logic [AW-1:0] o_dm_addr,
    output logic [3:0]    o_dm_be,
    output logic [DW-1:0] o_dm_wdata,
    input  logic          i_dm_gnt,
    input  logic          i_dm_rvalid,
    input  logic [DW-1:0] i_dm_rdata
);
    state_e        r_state, w_next;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata, r_lo, r_hi;
    logic [1:0]    r_len;
    logic          r_we, r_sign, r_cross;
    logic          w_idle, w_go, w_cross, w_req, w_beat2;
    logic [1:0]    w_off, w_len;
    logic          w_sign;
    logic [DW-1:0] w_wdata, w_rdata;
    logic [6:0]    w_mask;
    logic [63:0]   w_wdata64;

    assign w_idle = (r_state == S_IDLE);
    assign w_go   = i_req_valid & (i_mem_op[OP_MSB:OP_LSB] != MEM_NO_OP);

    // In IDLE the aligner sees the incoming request so crossing is known at accept time;
    // afterwards it works from the latched copy, keeping bus outputs register-derived.
    assign w_off   = w_idle ? i_addr[1:0] : r_addr[1:0];
    assign w_len   = w_idle ? i_mem_op[LEN_MSB:LEN_LSB] : r_len;
    assign w_sign  = w_idle ? i_mem_op[SIGN_BIT] : r_sign;
    assign w_wdata = w_idle ? i_wdata : r_wdata;
    assign w_cross = |w_mask[6:4];

    dmem_lane_align u_align (
        .i_off   (w_off),
        .i_len   (w_len),
        .i_sign  (w_sign),
        .i_wdata (w_wdata),
        .i_rword ({r_hi, r_lo}),
        .o_mask  (w_mask),
        .o_wdata (w_wdata64),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_len   <= '0;
            r_we    <= 1'b0;
            r_sign  <= 1'b0;
            r_cross <= 1'b0;
            r_lo    <= '0;
            r_hi    <= '0;
        end else begin
            if (w_idle && w_go) begin
                r_addr  <= i_addr;
                r_wdata <= i_wdata;
                r_len   <= i_mem_op[LEN_MSB:LEN_LSB];
                r_we    <= (i_mem_op[OP_MSB:OP_LSB] == MEM_WRITE);
                r_sign  <= i_mem_op[SIGN_BIT];
                r_cross <= w_cross;
                r_hi    <= '0;
            end
            if (r_state == S_WAIT1 && i_dm_rvalid) r_lo <= i_dm_rdata;
            if (r_state == S_WAIT2 && i_dm_rvalid) r_hi <= i_dm_rdata;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
`ifdef MEM_SPLIT_EN
            S_IDLE:  w_next = w_go ? S_REQ1 : S_IDLE;
            S_REQ1:  w_next = !i_dm_gnt ? S_REQ1 : !r_we ? S_WAIT1 : r_cross ? S_REQ2 : S_RESP;
            S_WAIT1: w_next = !i_dm_rvalid ? S_WAIT1 : r_cross ? S_REQ2 : S_RESP;
            S_REQ2:  w_next = !i_dm_gnt ? S_REQ2 : r_we ? S_RESP : S_WAIT2;
            S_WAIT2: w_next = i_dm_rvalid ? S_RESP : S_WAIT2;
`else
            S_IDLE:  w_next = !w_go ? S_IDLE : w_cross ? S_RESP : S_REQ1;
            S_REQ1:  w_next = !i_dm_gnt ? S_REQ1 : r_we ? S_RESP : S_WAIT1;
            S_WAIT1: w_next = i_dm_rvalid ? S_RESP : S_WAIT1;
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_req      = (r_state == S_REQ1) | (r_state == S_REQ2);
        w_beat2    = (r_state == S_REQ2);
        o_dm_req   = w_req;
        o_dm_we    = w_req & r_we;
        o_dm_addr  = !w_req ? '0 : {r_addr[AW-1:2] + (AW-2)'(w_beat2), 2'b00};
        o_dm_be    = !w_req ? '0 : w_beat2 ? {1'b0, w_mask[6:4]} : w_mask[3:0];
        o_dm_wdata = !(w_req & r_we) ? '0 : w_beat2 ? w_wdata64[63:32] : w_wdata64[31:0];
        o_done     = (r_state == S_RESP);
`ifdef MEM_SPLIT_EN
        o_misalign = 1'b0;
`else
        // Only a rejected crossing access reaches RESP with r_cross set in this build.
        o_misalign = o_done & r_cross;
`endif
        o_rdata    = (o_done & ~r_we & ~o_misalign) ? w_rdata : '0;
        o_stall    = w_go & (r_state != S_RESP);
    end
endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Data-memory access sequencer between the pipeline's MEM stage and the data-memory bus. It takes the 5-bit memory operation produced by instruction decode, plus the address and store data from the execute stage. It drives a request/grant/rvalid bus transaction, generates byte enables and lane-shifted write data, and returns sign- or zero-extended load data. It stalls the pipeline until the access completes. Word-crossing accesses are split into two bus beats when compiled in.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width (fixed at 32; 4 byte lanes)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous assert, active low
- req_valid  in  1  MEM stage holds a valid instruction
- mem_op  in  5  [4:3] op (NO_OP/READ/WRITE), [2] sign (SIGNED/UNSIGNED), [1:0] length (BYTE/HALF/WORD)
- addr  in  AW  byte address (rs1+imm)
- wdata  in  DW  store data, right-aligned
- stall  out  1  holds IF..MEM stages
- done  out  1  one-cycle completion pulse
- rdata  out  DW  extended load result, valid while done=1
- misalign  out  1  word-crossing access rejected (split disabled), valid with done
- dm_req  out  1  bus request
- dm_we  out  1  1=write
- dm_addr  out  AW  word-aligned address (low 2 bits zero)
- dm_be  out  4  byte enables
- dm_wdata  out  DW  lane-shifted store data
- dm_gnt  in  1  request accepted this cycle
- dm_rvalid  in  1  read data valid; arrives at least 1 cycle after its gnt
- dm_rdata  in  DW  read data

## Operation
- Offset: off = addr[1:0]. Lane mask m = {BYTE:0001, HALF:0011, WORD:1111} << off, giving 7 bits.
- Store data: wdata << 8*off, giving 64 bits. Beat 1 uses m[3:0] with data[31:0]. Beat 2 uses m[6:4] with data[63:32].
- Crossing: crossing = |m[6:4]. This covers HALF at off=3 and WORD at off≠0.
- Misaligned accesses inside a word (e.g. HALF at off=1) complete in one beat.
- FSM states: IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP.
- IDLE: if req_valid and op≠NO_OP, latch op, addr, shifted data and crossing.
  - If crossing and split is disabled, go to RESP with misalign=1.
  - Otherwise go to REQ1.
- REQ1: drive dm_req=1, dm_addr={addr[31:2],2'b00}, dm_be=m[3:0]. Hold all bus outputs stable until dm_gnt.
  - On gnt, a write goes to REQ2 if crossing, else RESP.
  - On gnt, a read goes to WAIT1.
- WAIT1: on dm_rvalid, capture the low word. Go to REQ2 if crossing, else RESP.
- REQ2: same as REQ1 with dm_addr = base+4 and dm_be = {1'b0, m[6:4]}.
  - On gnt, a write goes to RESP and a read goes to WAIT2.
- WAIT2: on dm_rvalid, capture the high word and go to RESP.
- RESP: done=1 and stall=0; always return to IDLE.
  - rdata = ({hi,lo} >> 8*off), truncated to the access length, then sign- or zero-extended.
- stall = req_valid & (op≠NO_OP) & (state≠RESP). Combinational, so it is high in the same cycle a new access appears in IDLE.
- When req_valid=1 with NO_OP: no stall, no bus activity, done stays 0.
- Writes complete on gnt with no rvalid. A dm_rvalid in a non-WAIT state is ignored.

## Timing
- Reset values: state IDLE; dm_req, dm_we, dm_be, dm_addr, dm_wdata, done, misalign and rdata all 0. stall is 0 while req_valid=0.
- Reset asserted mid-transaction drops dm_req immediately. Any outstanding rvalid after reset is ignored.
- Aligned write with zero-wait gnt: IDLE → REQ1 → RESP, so stall lasts 2 cycles.
- Aligned read with gnt at REQ1 and rvalid one cycle later: stall lasts 3 cycles.
- Each split beat adds at least 1 (write) or 2 (read) cycles.
- done is high only in RESP, exactly one cycle per accepted access. The pipeline advances at the end of RESP.
- dm_req may not drop until gnt. Outputs in REQ1/REQ2 are registered-stable.

## Configuration
- MEM_SPLIT_EN defined: crossing accesses become two beats. misalign is tied to 0.
- MEM_SPLIT_EN undefined: REQ2 and WAIT2 are not built. A crossing access issues no dm_req and returns done=1, misalign=1, rdata=0 after one IDLE cycle.

## Structure
- Shared package holds: MEM_NO_OP/MEM_READ/MEM_WRITE, MEM_SIGNED/MEM_UNSIGNED, MEM_BYTE/MEM_HALF/MEM_WORD, the mem_op field positions, and the FSM state enum.
- One sub-module, dmem_lane_align: combinational lane mask, write shift and load extract/extend.

## Test plan
- LW addr=0x100, dm_rdata=0x12345678, gnt immediate, rvalid +1 → rdata=0x12345678, done once, stall 3 cycles.
- LB signed addr=0x103, dm_rdata=0x80FFFFFF → rdata=0xFFFFFF80. LBU same → 0x00000080.
- SH addr=0x201, wdata=0xABCD → dm_be=0110, dm_wdata=0x00ABCD00, dm_we=1.
- SW addr=0x302, wdata=0x11223344, MEM_SPLIT_EN defined → beat 1 addr 0x300, be=1100, data 0x33440000; beat 2 addr 0x304, be=0011, data 0x00001122. Without MEM_SPLIT_EN: no dm_req, misalign=1.
- LW with dm_gnt held low 3 cycles → dm_req, dm_addr and dm_be stable throughout, stall high, then completion.
- rst_n low in WAIT1 → dm_req=0, done=0, state IDLE. A later rvalid has no effect.
